control_unit: RTL
=================

Name: control_unit

Overview:
- Instruction fetch/decode/sequencing FSM directly upstream of the datapath.
- Fetches a 16-bit instruction from an asynchronous-read instruction ROM addressed by the datapath PC.
- Decodes the instruction and drives every datapath control input: enable pulse, register select/write enables, ALU function/operand select, PC control, RAM enable.
- Waits on the datapath completion flag, with a timeout.

Parameters:
- DWIDTH, 16: instruction width (bits).
- TIMEOUT, 15: max WAIT cycles for dp_done before error; legal range 1..255.

Ports:
- clk  in  1  clock; one clock domain. One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin execution from IDLE; ignored in all other states.
- ins  in  DWIDTH  instruction word at the current PC (combinational ROM output).
- dp_done  in  1  datapath ALU completion flag (datapath en_out).
- en_dp  out  1  datapath/register-group enable pulse.
- en_pc_pulse  out  1  PC update strobe.
- pc_ctrl  out  2  PC op: 00 hold, 01 increment, 10 load offset_addr, 11 reserved (treated as hold).
- offset_addr  out  8  jump target / RAM address (ir[7:0]).
- offset  out  8  immediate (ir[7:0]).
- rd  out  2  destination register (ir[11:10]).
- rs  out  2  source register (ir[9:8]).
- reg_en  out  4  one-hot register write enable.
- alu_func  out  3  ALU op.
- alu_in_sel  out  1  1 = immediate operand.
- ram_en  out  1  RAM path select.
- ram_we  out  1  RAM write strobe.
- busy  out  1  high when not in IDLE, HALT or ERR.
- halted  out  1  HALT executed.
- err  out  1  timeout or illegal opcode.

Behaviour:
- Reset: all outputs 0; state IDLE; ir = 0; WAIT counter = 0. Reset is asynchronous, so reset mid-instruction aborts immediately with no partial pulses.
- Instruction format: ir[15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm/addr.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: alu_func 000..100, alu_in_sel 0.
  - 6 ADDI: alu_func 000, alu_in_sel 1.
  - 7 LOAD: rd <= RAM[addr].
  - 8 STORE: RAM[addr] <= rs.
  - 9 JMP.
  - F HALT.
  - Others illegal.
- All outputs are registered (Moore, from state and ir).
- rd, rs, offset, offset_addr, alu_func and alu_in_sel are stable from the cycle after DECODE until the next FETCH.
- States and transitions:
  - IDLE: start=1 -> FETCH.
  - FETCH (1 cycle): ir <= ins -> DECODE.
  - DECODE (1 cycle):
    - ALU ops -> EXEC.
    - LOAD/STORE -> WB.
    - NOP/JMP -> PC_UPD.
    - HALT -> HALT.
    - Illegal -> ERR.
  - EXEC: en_dp=1 for 1 cycle, reg_en=0 (operand capture) -> WAIT.
  - WAIT: counter increments each cycle.
    - dp_done=1 -> WB.
    - Counter reaches TIMEOUT without dp_done -> ERR.
    - dp_done in the same cycle the timeout is reached: done wins.
  - WB (1 cycle): behaviour by opcode:
    - ALU ops: en_dp=1, reg_en=onehot(rd).
    - LOAD: ram_en=1, en_dp=1, reg_en=onehot(rd).
    - STORE: ram_en=1, ram_we=1, reg_en=0.
    - Then -> PC_UPD.
  - PC_UPD (1 cycle): en_pc_pulse=1; pc_ctrl=10 for JMP, 01 otherwise -> FETCH.
  - HALT: halted=1; exit only by reset.
  - ERR: err=1; exit only by reset.
- Timing:
  - FETCH samples ins one full cycle after the PC_UPD edge, so the ROM must be asynchronous-read.
  - ALU instruction latency = 5 + WAIT cycles; minimum 6 cycles/instruction.
  - LOAD/STORE: 4 cycles.
  - NOP/JMP: 3 cycles.
- dp_done outside WAIT is ignored.
- en_dp, en_pc_pulse and ram_we are never high in the same cycle.
- The WAIT counter clears on WAIT entry.

Optional Feature:
- Macro CU_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit) and state STEP.
  - PC_UPD -> STEP; STEP -> FETCH on step=1; busy stays high in STEP.
  - step is ignored in other states.
- Undefined: no step port; PC_UPD -> FETCH directly.

Test Plan:
- Reset then start with ins=0x1600 (ADD r1,r2), dp_done asserted 1 cycle after the en_dp pulse:
  - FETCH/DECODE/EXEC/WAIT/WB/PC_UPD take 6 cycles.
  - WB has reg_en=0010, en_dp=1.
  - PC_UPD has pc_ctrl=01.
- ins=0x6405 (ADDI r1,5): alu_in_sel=1, offset=0x05, alu_func=000, reg_en=0010 at WB.
- ins=0x7C20 (LOAD r3,[0x20]) then 0x8820 (STORE from r0):
  - LOAD WB: ram_en=1, reg_en=1000.
  - STORE WB: ram_we=1 for exactly 1 cycle, reg_en=0.
  - Each instruction takes 4 cycles.
- ins=0x9012 (JMP 0x12): no en_dp; PC_UPD has pc_ctrl=10, offset_addr=0x12; next FETCH follows the PC_UPD cycle.
- ADD with dp_done held low and TIMEOUT=15: ERR entered after 15 WAIT cycles, err=1, busy=0, no WB. ins=0xB000 (illegal) -> ERR after DECODE.
- ins=0xF000 (HALT): halted=1, start ignored. Assert rst in WAIT mid-ADD: all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/control_unit.sv
// Fetch/decode/sequencing FSM driving the datapath controls; all outputs registered.
// Optional single-step mode (extra `step` input and STEP state) under CU_SINGLE_STEP_EN.
module control_unit #(
    parameter int DWIDTH  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DWIDTH-1:0] ins,
    input  logic              dp_done,
`ifdef CU_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic              en_dp,
    output logic              en_pc_pulse,
    output logic [1:0]        pc_ctrl,
    output logic [7:0]        offset_addr,
    output logic [7:0]        offset,
    output logic [1:0]        rd,
    output logic [1:0]        rs,
    output logic [3:0]        reg_en,
    output logic [2:0]        alu_func,
    output logic              alu_in_sel,
    output logic              ram_en,
    output logic              ram_we,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_WB, S_PC_UPD, S_HALT, S_ERR
`ifdef CU_SINGLE_STEP_EN
        , S_STEP
`endif
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h6;
    localparam logic [3:0] OP_LOAD  = 4'h7;
    localparam logic [3:0] OP_STORE = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    logic [DWIDTH-1:0] ir;
    logic [7:0]        wait_cnt;
    logic [3:0]        op;
    logic              is_alu;
    logic [3:0]        rd_onehot;

    assign op        = ir[15:12];
    assign is_alu    = (op >= 4'h1) && (op <= OP_ADDI);
    assign rd_onehot = 4'b0001 << ir[11:10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ir          <= '0;
            wait_cnt    <= '0;
            en_dp       <= 1'b0;
            en_pc_pulse <= 1'b0;
            pc_ctrl     <= 2'b00;
            offset_addr <= '0;
            offset      <= '0;
            rd          <= '0;
            rs          <= '0;
            reg_en      <= '0;
            alu_func    <= '0;
            alu_in_sel  <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
        end else begin
            // strobes are single-cycle; each branch below raises those of the state it enters
            en_dp       <= 1'b0;
            en_pc_pulse <= 1'b0;
            pc_ctrl     <= 2'b00;
            reg_en      <= '0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    ir    <= ins;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    rd          <= ir[11:10];
                    rs          <= ir[9:8];
                    offset      <= ir[7:0];
                    offset_addr <= ir[7:0];
                    alu_func    <= (is_alu && op != OP_ADDI) ? 3'(op - 4'd1) : 3'b000;
                    alu_in_sel  <= (op == OP_ADDI);
                    if (is_alu) begin
                        state <= S_EXEC;
                        en_dp <= 1'b1;
                    end else if (op == OP_LOAD) begin
                        state  <= S_WB;
                        ram_en <= 1'b1;
                        en_dp  <= 1'b1;
                        reg_en <= rd_onehot;
                    end else if (op == OP_STORE) begin
                        state  <= S_WB;
                        ram_en <= 1'b1;
                        ram_we <= 1'b1;
                    end else if (op == OP_NOP || op == OP_JMP) begin
                        state       <= S_PC_UPD;
                        en_pc_pulse <= 1'b1;
                        pc_ctrl     <= (op == OP_JMP) ? 2'b10 : 2'b01;
                    end else if (op == OP_HALT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        state <= S_ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_EXEC: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    // completion is checked first so a late dp_done still beats the timeout
                    if (dp_done) begin
                        state  <= S_WB;
                        en_dp  <= 1'b1;
                        reg_en <= rd_onehot;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_WB: begin
                    state       <= S_PC_UPD;
                    en_pc_pulse <= 1'b1;
                    pc_ctrl     <= 2'b01;
                end
                S_PC_UPD: begin
`ifdef CU_SINGLE_STEP_EN
                    state <= S_STEP;
`else
                    state <= S_FETCH;
`endif
                end
`ifdef CU_SINGLE_STEP_EN
                S_STEP: begin
                    if (step) state <= S_FETCH;
                end
`endif
                S_HALT: state <= S_HALT;
                S_ERR:  state <= S_ERR;
                default: begin
                    state <= S_ERR;
                    err   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
